// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared types for the VGA timing generator: the pattern mode encoding,
//   the colour-bar table (1 bit per channel, {r,g,b}) and the 11-bit
//   counter type. Eleven bits cover line/frame totals up to 2047.
package vga_timing_pkg;

  typedef logic [10:0] cnt_t;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_t;

  // Bars from left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// vga_pix_ce
//   Run/stop toggle and pixel clock-enable divider.
//   Ports:
//     s_clk, s_rst_n : system clock, asynchronous active-low reset
//     key_en         : asynchronous level from the debouncer; a rising edge toggles run/stop
//     ce             : pixel enable, one s_clk in every DIV
//     running        : registered run state
//     run_next       : run state for the coming cycle; the top uses it so that a
//                      stop clears everything on the same edge that clears running
module vga_pix_ce
  import vga_timing_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic s_clk,
  input  logic s_rst_n,
  input  logic key_en,
  output logic ce,
  output logic running,
  output logic run_next
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [2:0]    key_sync;   // [0],[1] synchroniser, [2] previous value for edge detect
  logic [DW-1:0] div_cnt;
  logic          key_rise;

  assign key_rise = key_sync[1] & ~key_sync[2];
  assign run_next = running ^ key_rise;
  // Qualified with run_next so the first pixel after a start lasts exactly DIV cycles.
  assign ce       = run_next && (div_cnt == DW'(DIV - 1));

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      key_sync <= '0;
      running  <= 1'b0;
      div_cnt  <= '0;
    end else begin
      key_sync <= {key_sync[1:0], key_en};
      running  <= run_next;
      if (!run_next || ce) div_cnt <= '0;
      else                 div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA timing and test-pattern generator (pixel rate s_clk/DIV).
//   Ports:
//     s_clk, s_rst_n      : system clock, asynchronous active-low reset
//     key_en              : async run/stop toggle (rising edge)
//     mode                : 0 bars, 1 checker, 2 solid, 3 grey ramp
//     solid_rgb           : {r,g,b} colour for solid mode
//     red, green, blue    : pixel colour, zero outside the active area
//     hysy, vysy          : horizontal / vertical sync (polarity by SYNC_POL)
//     de                  : data enable
//     pix_x, pix_y        : active-area coordinates, zero when de=0
//     frame_end           : one-cycle pulse on the last pixel of each frame
//     running             : run state
//   Build option: define VGA_BORDER_EN to overlay a 1-px white frame on every pattern.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int COLOR_W = 4,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                 s_clk,
  input  logic                 s_rst_n,
  input  logic                 key_en,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 hysy,
  output logic                 vysy,
  output logic                 de,
  output logic [10:0]          pix_x,
  output logic [10:0]          pix_y,
  output logic                 frame_end,
  output logic                 running
);

  localparam cnt_t H_LAST = cnt_t'(H_SYNC + H_BP + H_ACT + H_FP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_SYNC + V_BP + V_ACT + V_FP - 1);
  localparam cnt_t H_SYN  = cnt_t'(H_SYNC);
  localparam cnt_t V_SYN  = cnt_t'(V_SYNC);
  localparam cnt_t H_BEG  = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t V_BEG  = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t H_END  = cnt_t'(H_SYNC + H_BP + H_ACT);
  localparam cnt_t V_END  = cnt_t'(V_SYNC + V_BP + V_ACT);
  localparam cnt_t BAR_W  = cnt_t'((H_ACT >= 8) ? H_ACT / 8 : 1);

  logic ce, run_next, start;
  cnt_t h_cnt, v_cnt;
  logic h_last, v_last, at_origin;

  mode_t                mode_q;
  logic [3*COLOR_W-1:0] solid_q;

  logic                 de_n;
  cnt_t                 px, py, bar_idx;
  logic [2:0]           bar_c;
  logic [3*COLOR_W-1:0] rgb_n;

  vga_pix_ce #(.DIV(DIV)) u_pix_ce (
    .s_clk    (s_clk),
    .s_rst_n  (s_rst_n),
    .key_en   (key_en),
    .ce       (ce),
    .running  (running),
    .run_next (run_next)
  );

  assign start     = run_next & ~running;
  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run_next) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + cnt_t'(1);
      end else begin
        h_cnt <= h_cnt + cnt_t'(1);
      end
    end
  end

  // Pattern selection only changes at the frame origin so a frame never tears.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      mode_q  <= MODE_BARS;
      solid_q <= '0;
    end else if (start || (ce && at_origin)) begin
      mode_q  <= mode_t'(mode);
      solid_q <= solid_rgb;
    end
  end

  assign de_n    = (h_cnt >= H_BEG) && (h_cnt < H_END) && (v_cnt >= V_BEG) && (v_cnt < V_END);
  assign px      = de_n ? h_cnt - H_BEG : '0;
  assign py      = de_n ? v_cnt - V_BEG : '0;
  assign bar_idx = px / BAR_W;
  assign bar_c   = (bar_idx < cnt_t'(8)) ? bar_rgb(bar_idx[2:0]) : 3'b000;

  always_comb begin
    rgb_n = '0;
    if (de_n) begin
      case (mode_q)
        MODE_BARS:  rgb_n = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}};
        MODE_CHECK: rgb_n = (px[5] ^ py[5]) ? '1 : '0;
        MODE_SOLID: rgb_n = solid_q;
        MODE_GRAD:  rgb_n = {3{px[9 -: COLOR_W]}};
        default:    rgb_n = '0;
      endcase
`ifdef VGA_BORDER_EN
      if ((px == '0) || (px == cnt_t'(H_ACT - 1)) || (py == '0) || (py == cnt_t'(V_ACT - 1)))
        rgb_n = '1;
`endif
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      hysy      <= ~SYNC_POL;
      vysy      <= ~SYNC_POL;
      de        <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      frame_end <= 1'b0;
      {red, green, blue} <= '0;
    end else if (!run_next) begin
      hysy      <= ~SYNC_POL;
      vysy      <= ~SYNC_POL;
      de        <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      frame_end <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      hysy      <= (h_cnt < H_SYN) ? SYNC_POL : ~SYNC_POL;
      vysy      <= (v_cnt < V_SYN) ? SYNC_POL : ~SYNC_POL;
      de        <= de_n;
      pix_x     <= px;
      pix_y     <= py;
      // Gated by run_next above, so a stop landing on the frame wrap suppresses the pulse.
      frame_end <= ce & h_last & v_last;
      {red, green, blue} <= rgb_n;
    end
  end

endmodule
